divider_fsm: RTL and testbench

//  32-bit unsigned sequential divider (restoring shift-subtract, 1 quotient bit/cycle).

---
 rtl/divider_fsm.sv | 117 +++++++++++
 tb/tb_divider_fsm.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/divider_fsm.sv
// Unsigned restoring divider, one quotient bit per cycle, IDLE/EXEC/DONE start/clear protocol.
// Latency 34 edges from start to op_done; dropping op_start in EXEC stalls it, op_clear aborts.
module divider_fsm #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             op_start,
    input  logic             op_clear,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             op_done,
    output logic             div_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;

    logic [WIDTH-1:0]   rem_sh;
    logic [WIDTH-1:0]   quo_sh;
    logic [WIDTH:0]     trial;

    // The partial remainder stays below 2^(WIDTH-1) before every shift, so no bit is lost here.
    assign rem_sh = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    assign quo_sh = {quo_q[WIDTH-2:0], 1'b0};
    assign trial  = {1'b0, rem_sh} - {1'b0, dvs_q};

    always_ff @(posedge clk) begin
        if (!reset_n || op_clear) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            dvs_q       <= dvs_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        dvs_d       = dvs_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        case (state_q)
            S_IDLE: begin
                if (op_start) begin
                    state_d = S_EXEC;
                    dvs_d   = divisor;
                    quo_d   = dividend;
                    rem_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_EXEC: begin
                if (op_start) begin
                    if (cnt_q < CNT_LAST) begin
                        if (!trial[WIDTH]) begin
                            rem_d = trial[WIDTH-1:0];
                            quo_d = quo_sh | WIDTH'(1);
                        end else begin
                            rem_d = rem_sh;
                            quo_d = quo_sh;
                        end
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        state_d     = S_DONE;
                        quotient_d  = quo_q;
                        remainder_d = rem_q;
                    end
                end
            end
            S_DONE: begin
                if (!op_start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign op_done   = (state_q == S_DONE);
    assign div_zero  = (state_q == S_DONE) && (dvs_q == '0);

endmodule

// File: tb/tb_divider_fsm.sv
// Randomised bench for divider_fsm against plain / and % arithmetic, plus stall, clear and reset cases.
module tb_divider_fsm;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         op_start;
    logic         op_clear;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         op_done;
    logic         div_zero;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    divider_fsm #(.WIDTH(W), .CNT_W(6)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .op_start  (op_start),
        .op_clear  (op_clear),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .op_done   (op_done),
        .div_zero  (div_zero)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a division from IDLE, optionally stall or scramble operands, then return to IDLE.
    task automatic run_div(input string tag, input logic [W-1:0] n, input logic [W-1:0] d,
                           input int stall_at, input int stall_len, input bit scramble,
                           input bit prop);
        int           edges;
        logic [W-1:0] q_exp, r_exp;
        logic [63:0]  recon;
        if (d == 0) begin
            q_exp = '1;
            r_exp = n;
        end else begin
            q_exp = n / d;
            r_exp = n % d;
        end
        dividend = n;
        divisor  = d;
        op_start = 1'b1;
        edges    = 0;
        while (!op_done && edges < 100) begin
            tick();
            edges++;
            if (scramble) begin
                dividend = $urandom;
                divisor  = $urandom;
            end
            if (stall_len > 0 && edges == stall_at) op_start = 1'b0;
            if (stall_len > 0 && edges == stall_at + stall_len) op_start = 1'b1;
        end
        check({tag, " latency"}, 64'(edges), 64'(34 + stall_len));
        check({tag, " quotient"}, 64'(quotient), 64'(q_exp));
        check({tag, " remainder"}, 64'(remainder), 64'(r_exp));
        check({tag, " div_zero"}, 64'(div_zero), 64'(d == 0));
        if (prop && d != 0) begin
            recon = 64'(quotient) * 64'(d) + 64'(remainder);
            check({tag, " q*d+r"}, recon, 64'(n));
            check({tag, " r<d"}, 64'(remainder < d), 64'd1);
        end
        tick();
        check({tag, " done hold"}, 64'(op_done), 64'd1);
        check({tag, " quotient hold"}, 64'(quotient), 64'(q_exp));
        op_start = 1'b0;
        tick();
        check({tag, " done drop"}, 64'(op_done), 64'd0);
        check({tag, " div_zero drop"}, 64'(div_zero), 64'd0);
        check({tag, " quotient kept"}, 64'(quotient), 64'(q_exp));
        check({tag, " remainder kept"}, 64'(remainder), 64'(r_exp));
    endtask

    // Abort a 100/7 run once count has reached 10, via op_clear or reset_n.
    task automatic abort_mid(input string tag, input bit use_reset);
        dividend = 100;
        divisor  = 7;
        op_start = 1'b1;
        repeat (11) tick();
        op_start = 1'b0;
        if (use_reset) reset_n = 1'b0;
        else op_clear = 1'b1;
        tick();
        check({tag, " done"}, 64'(op_done), 64'd0);
        check({tag, " quotient"}, 64'(quotient), 64'd0);
        check({tag, " remainder"}, 64'(remainder), 64'd0);
        reset_n  = 1'b1;
        op_clear = 1'b0;
        tick();
        check({tag, " still idle"}, 64'(op_done), 64'd0);
    endtask

    initial begin
        logic [W-1:0] n, d;
        reset_n  = 1'b0;
        op_start = 1'b1;
        op_clear = 1'b0;
        dividend = 32'd55;
        divisor  = 32'd3;
        repeat (3) tick();
        check("reset op_done", 64'(op_done), 64'd0);
        check("reset div_zero", 64'(div_zero), 64'd0);
        check("reset quotient", 64'(quotient), 64'd0);
        check("reset remainder", 64'(remainder), 64'd0);
        op_start = 1'b0;
        reset_n  = 1'b1;
        tick();
        check("idle no start", 64'(op_done), 64'd0);

        run_div("100/7", 32'd100, 32'd7, 0, 0, 1'b0, 1'b1);
        run_div("max/1", 32'hFFFF_FFFF, 32'd1, 0, 0, 1'b0, 1'b1);
        run_div("5/9", 32'd5, 32'd9, 0, 0, 1'b0, 1'b1);
        run_div("1234/0", 32'd1234, 32'd0, 0, 0, 1'b0, 1'b0);
        run_div("stall 100/7", 32'd100, 32'd7, 12, 5, 1'b1, 1'b1);
        run_div("max/big", 32'hFFFF_FFFF, 32'hC000_0001, 0, 0, 1'b1, 1'b1);

        abort_mid("clear", 1'b0);
        run_div("after clear", 32'd100, 32'd7, 0, 0, 1'b0, 1'b1);
        abort_mid("reset", 1'b1);
        run_div("after reset", 32'd5, 32'd9, 0, 0, 1'b0, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            n = $urandom;
            case ($urandom_range(0, 7))
                0:       d = 32'd0;
                1, 2:    d = $urandom_range(1, 255);
                3, 4:    d = $urandom >> $urandom_range(0, 31);
                default: d = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0)
                run_div("rand", n, d, $urandom_range(2, 30), $urandom_range(1, 4), 1'b1, 1'b1);
            else
                run_div("rand", n, d, 0, 0, $urandom_range(0, 1) == 1, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
